// File: rtl/sram_mem_ctrl_pkg.sv
// Shared definitions for the SRAM memory controller.
//   sram_state_e     : controller state encoding (2 bits)
//   SRAM_WAIT_CYCLES : default SRAM cycles per 16-bit half-access (legal 2..15)
//   SRAM_BASE_ADDR   : default CPU byte address that maps to SRAM word 0
//   SRAM_ADDR_W      : default SRAM half-word address width
package sram_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } sram_state_e;

    localparam int SRAM_WAIT_CYCLES = 5;
    localparam int SRAM_BASE_ADDR   = 1024;
    localparam int SRAM_ADDR_W      = 18;

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// Bus between the MEM stage, the SRAM controller and the SRAM pads.
//   MEM_R_ENIn/MEM_W_ENIn/addressIn/writeDataIn : request from the MEM stage
//   readDataOut/readyOut                        : load result and freeze release
//   sramAddrOut/sramDqOut/sramDqOeOut/sramWeNOut: SRAM pad drivers
//   sramDqIn                                    : SRAM read data
// master: the CPU/SRAM side; slave: the controller.
interface sram_mem_ctrl_if
    import sram_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W
);
    logic              MEM_R_ENIn;
    logic              MEM_W_ENIn;
    logic [31:0]       addressIn;
    logic [31:0]       writeDataIn;
    logic [31:0]       readDataOut;
    logic              readyOut;
    logic [ADDR_W-1:0] sramAddrOut;
    logic [15:0]       sramDqOut;
    logic [15:0]       sramDqIn;
    logic              sramDqOeOut;
    logic              sramWeNOut;

    modport master (
        output MEM_R_ENIn, MEM_W_ENIn, addressIn, writeDataIn, sramDqIn,
        input  readDataOut, readyOut, sramAddrOut, sramDqOut, sramDqOeOut, sramWeNOut
    );

    modport slave (
        input  MEM_R_ENIn, MEM_W_ENIn, addressIn, writeDataIn, sramDqIn,
        output readDataOut, readyOut, sramAddrOut, sramDqOut, sramDqOeOut, sramWeNOut
    );
endinterface

// File: rtl/sram_wait_counter.sv
// Wait-state counter shared by both half-accesses of a transaction.
//   clk, rst    : clock, async active-low reset
//   clear       : synchronous return to 0 (wins over enable)
//   enable      : count up by one
//   terminalOut : count == WAIT_CYCLES-1
module sram_wait_counter
    import sram_mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = SRAM_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminalOut
);
    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    logic [3:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 4'd1;
        end
    end

    assign terminalOut = (count == LAST);
endmodule

// File: rtl/sram_mem_ctrl.sv
// Multi-cycle controller for a 16-bit async SRAM used as CPU data memory.
// Each 32-bit access becomes a low half (even address) then a high half
// (odd address), each WAIT_CYCLES long; readyOut freezes the pipeline meanwhile.
//   clk, rst : clock, async active-low reset
//   bus      : sram_mem_ctrl_if.slave (MEM-stage request + SRAM pads)
// Optional build macro SRAM_MEM_CTRL_STATS_EN adds:
//   accessCountOut : completed transactions (DONE cycles)
//   stallCountOut  : cycles with readyOut low
module sram_mem_ctrl
    import sram_mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = SRAM_WAIT_CYCLES,
    parameter int BASE_ADDR   = SRAM_BASE_ADDR,
    parameter int ADDR_W      = SRAM_ADDR_W
) (
    input  logic clk,
    input  logic rst,
    sram_mem_ctrl_if.slave bus
`ifdef SRAM_MEM_CTRL_STATS_EN
    ,
    output logic [31:0] accessCountOut,
    output logic [31:0] stallCountOut
`endif
);
    sram_state_e       state, state_nxt;
    logic              req;
    logic              ready;
    logic              in_phase;
    logic              half;
    logic              cnt_term;
    logic              cnt_clear;
    logic              op_wr;
    logic [31:0]       wdata;
    logic [31:0]       offset_full;
    logic [ADDR_W-2:0] word_addr;
    logic [ADDR_W-1:0] addr_now;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       rdata;
    logic              unused_offset_bits;

    assign req         = bus.MEM_R_ENIn | bus.MEM_W_ENIn;
    assign offset_full = bus.addressIn - 32'(BASE_ADDR);
    // Only the SRAM word index is kept; byte lane and out-of-range bits are dropped.
    assign unused_offset_bits = ^{offset_full[31:ADDR_W+1], offset_full[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        in_phase  = 1'b0;
        half      = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = !req;
                if (req) state_nxt = ST_LOW;
            end
            ST_LOW: begin
                in_phase = 1'b1;
                if (cnt_term) state_nxt = ST_HIGH;
            end
            ST_HIGH: begin
                in_phase = 1'b1;
                half     = 1'b1;
                if (cnt_term) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                ready     = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Counter restarts on every phase boundary, so one instance serves both halves.
    assign cnt_clear = !in_phase || cnt_term;

    sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk         (clk),
        .rst         (rst),
        .clear       (cnt_clear),
        .enable      (in_phase),
        .terminalOut (cnt_term)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_wr     <= 1'b0;
            wdata     <= '0;
            word_addr <= '0;
            addr_q    <= '0;
            rdata     <= '0;
        end else begin
            if (state == ST_IDLE && req) begin
                op_wr     <= bus.MEM_W_ENIn;
                wdata     <= bus.writeDataIn;
                word_addr <= offset_full[ADDR_W:2];
            end
            if (in_phase) addr_q <= addr_now;
            if (in_phase && !op_wr && cnt_term) begin
                if (half) rdata[31:16] <= bus.sramDqIn;
                else      rdata[15:0]  <= bus.sramDqIn;
            end
        end
    end

    assign addr_now        = {word_addr, half};
    assign bus.readyOut    = ready;
    assign bus.readDataOut = rdata;
    assign bus.sramAddrOut = in_phase ? addr_now : addr_q;
    assign bus.sramDqOut   = (in_phase && op_wr) ? (half ? wdata[31:16] : wdata[15:0]) : 16'h0000;
    assign bus.sramDqOeOut = in_phase && op_wr;
    // WE rises on the terminal cycle while data is still driven, giving hold time.
    assign bus.sramWeNOut  = !(in_phase && op_wr && !cnt_term);

`ifdef SRAM_MEM_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            accessCountOut <= '0;
            stallCountOut  <= '0;
        end else begin
            if (state == ST_DONE) accessCountOut <= accessCountOut + 32'd1;
            if (!ready)           stallCountOut  <= stallCountOut + 32'd1;
        end
    end
`endif
endmodule
